// File: rtl/demux_sched_pkg.sv
// Shared constants, FSM state type and one-hot helper for the demux scheduler.
// Included by rr_pick and demux_sched.
package demux_sched_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;
    localparam int CNTW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] sel_onehot(input logic [SELW-1:0] idx);
        return NCH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set search over an 8-bit mask, starting at ptr.
// Latency: combinational. Backpressure: none (pure function of inputs).
// No set bit: found = 0, idx = ptr.
module rr_pick
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[ptr + SELW'(i)]) begin
                idx   = ptr + SELW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// Routes each input item to one of 8 channels via a one-entry output register; round-robin target.
// Latency: 1 cycle accept-to-out_valid. Backpressure: in_ready follows the targeted out_ready while full.
// DEMUX_SCHED_SKIP_EN: skip channels disabled in en_mask (default: strict rotation, en_mask ignored).
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [NCH-1:0]  en_mask,
    output logic [NCH-1:0]  out_valid,
    input  logic [NCH-1:0]  out_ready,
    output logic [DW-1:0]   out_data,
    output logic [SELW-1:0] out_sel,
    output logic            busy,
    output logic [CNTW-1:0] xfer_cnt
);

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] sel_q;
    logic [NCH-1:0]  vld_q;
    logic [DW-1:0]   dat_q;
    logic [CNTW-1:0] cnt_q;

    logic            drain;
    logic            accept;
    logic [SELW-1:0] base_ptr;
    logic [NCH-1:0]  pick_mask;
    logic [SELW-1:0] pick_idx;
    logic            pick_found;

`ifdef DEMUX_SCHED_SKIP_EN
    assign pick_mask = en_mask;
`else
    logic unused_en_mask;
    assign pick_mask      = '1;
    assign unused_en_mask = ^en_mask;
`endif

    assign drain = (state == HOLD) && out_ready[sel_q];

    // A refill in the drain cycle must search from the post-drain pointer.
    assign base_ptr = drain ? sel_q + SELW'(1) : ptr;

    rr_pick u_pick (
        .mask  (pick_mask),
        .ptr   (base_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign in_ready = rst_n && ((state == IDLE) || drain) && pick_found;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            vld_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            if (drain) begin
                cnt_q <= cnt_q + CNTW'(1);
                ptr   <= sel_q + SELW'(1);
            end
            if (accept) begin
                state <= HOLD;
                sel_q <= pick_idx;
                vld_q <= sel_onehot(pick_idx);
                dat_q <= in_data;
            end else if (drain) begin
                state <= IDLE;
                vld_q <= '0;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_data  = dat_q;
    assign out_sel   = sel_q;
    assign busy      = (state == HOLD);
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
// Directed + randomized bench for demux_sched against a queue-free behavioural model.
module tb_demux_sched;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [7:0]    en_mask;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_sel;
    logic          busy;
    logic [15:0]   xfer_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit quiet = 0;

    // Reference model state
    bit         m_busy;
    int         m_sel;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_data;

    demux_sched #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] m, input int base);
`ifdef DEMUX_SCHED_SKIP_EN
        for (int k = 0; k < 8; k++)
            if (m[(base + k) % 8]) return (base + k) % 8;
`endif
        return base;
    endfunction

    task automatic check_outputs();
        logic [7:0] exp_v;
        exp_v = m_busy ? (8'd1 << m_sel) : 8'd0;
        chk("out_valid", out_valid, exp_v);
        chk("busy", busy, m_busy);
        chk("xfer_cnt", xfer_cnt, m_cnt);
        if (m_busy) begin
            chk("out_sel", out_sel, m_sel);
            chk("out_data", out_data, m_data);
        end
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [7:0] m, input logic [7:0] r);
        logic exp_rdy;
        logic acc;
        logic drn;
        in_valid  = v;
        in_data   = d;
        en_mask   = m;
        out_ready = r;
        #1;
        exp_rdy = !m_busy || r[m_sel];
`ifdef DEMUX_SCHED_SKIP_EN
        if (m == 8'h00) exp_rdy = 1'b0;
`endif
        if (!quiet) chk("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        drn = m_busy && r[m_sel];
        @(posedge clk);
        if (drn) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_ptr = (m_sel + 1) % 8;
        end
        if (acc) begin
            m_sel  = pick(m, m_ptr);
            m_data = d;
            m_busy = 1;
        end else if (drn) begin
            m_busy = 0;
        end
        @(negedge clk);
        if (!quiet) check_outputs();
    endtask

    // Entered at a negedge; asserts reset asynchronously mid-cycle and releases at a later negedge.
    task automatic do_reset();
        in_valid  = 1'b1;
        out_ready = 8'hFF;
        en_mask   = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_data = 8'h00;
        chk("rst_out_valid", out_valid, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_xfer_cnt", xfer_cnt, 16'h0000);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_sel", out_sel, 3'd0);
        chk("rst_out_data", out_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] r;
        int exp_tgt[4];
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        en_mask   = 8'hFF;
        out_ready = 8'h00;
        @(negedge clk);
        do_reset();

        // Back-to-back stream, every channel ready: strict order 0..7.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 8'h10 + 8'(k), 8'hFF, 8'hFF);
            chk("seq_sel", out_sel, k);
            chk("seq_data", out_data, 8'h10 + 8'(k));
        end
        cycle(1'b0, 8'h00, 8'hFF, 8'hFF);
        chk("seq_cnt", xfer_cnt, 16'd8);

        // Stall on channel 0, ignoring other channels' ready, then release.
        do_reset();
        cycle(1'b1, 8'hA5, 8'hFF, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 8'h3C, 8'hFF, 8'hFE);
            chk("stall_vld", out_valid, 8'h01);
            chk("stall_data", out_data, 8'hA5);
        end
        cycle(1'b0, 8'h00, 8'hFF, 8'h01);
        chk("stall_cnt", xfer_cnt, 16'd1);

        do_reset();
`ifdef DEMUX_SCHED_SKIP_EN
        exp_tgt = '{2, 5, 2, 5};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 8'h40 + 8'(k), 8'h24, 8'hFF);
            chk("skip_sel", out_sel, exp_tgt[k]);
        end
        cycle(1'b0, 8'h00, 8'h24, 8'hFF);
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'h50, 8'h00, 8'hFF);
        chk("skip_none_busy", busy, 1'b0);
`else
        exp_tgt = '{0, 1, 2, 3};
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 8'h40 + 8'(k), 8'h00, 8'hFF);
            chk("rot_sel", out_sel, exp_tgt[k]);
        end
        cycle(1'b0, 8'h00, 8'h00, 8'hFF);
`endif

        // Randomized traffic, masks and backpressure.
        for (int k = 0; k < 400; k++) begin
            m = 8'($urandom);
            if ($urandom_range(0, 3) == 0) m = 8'hFF;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = 8'hFF;
            cycle(1'($urandom_range(0, 1)), 8'($urandom), m, r);
        end

        // Counter wrap and pointer wrap.
        do_reset();
        quiet = 1;
        for (int k = 0; k < 65535; k++) cycle(1'b1, 8'(k), 8'hFF, 8'hFF);
        quiet = 0;
        cycle(1'b0, 8'h00, 8'hFF, 8'hFF);
        chk("pre_wrap_cnt", xfer_cnt, 16'hFFFF);
        cycle(1'b1, 8'h77, 8'hFF, 8'h00);
        chk("wrap_sel7", out_sel, 3'd7);
        cycle(1'b0, 8'h00, 8'hFF, 8'hFF);
        chk("wrap_cnt", xfer_cnt, 16'h0000);
        cycle(1'b1, 8'h88, 8'hFF, 8'h00);
        chk("wrap_ptr0", out_sel, 3'd0);

        // Reset while holding discards the item.
        cycle(1'b1, 8'h99, 8'hFF, 8'h00);
        chk("hold_before_rst", busy, 1'b1);
        do_reset();
        cycle(1'b1, 8'h5A, 8'hFF, 8'h00);
        chk("post_rst_sel", out_sel, 3'd0);
        chk("post_rst_vld", out_valid, 8'h01);
        cycle(1'b0, 8'h00, 8'hFF, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter DW, default 8, SHALL set the data width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  SHALL signal that upstream offers an item.
REQ-005 in_ready  output  1  SHALL signal that the block accepts an item this cycle.
REQ-006 in_data  input  DW  SHALL carry the upstream item.
REQ-007 en_mask  input  8  SHALL mark which destination channels are enabled (bit i = channel i).
REQ-008 out_valid  output  8  SHALL be one-hot (or zero) and mark the channel the held item targets.
REQ-009 out_ready  input  8  SHALL carry the per-channel downstream ready.
REQ-010 out_data  output  DW  SHALL carry the held item, shared by all channels.
REQ-011 out_sel  output  3  SHALL carry the binary index of the targeted channel.
REQ-012 busy  output  1  SHALL be high while an item is held.
REQ-013 xfer_cnt  output  16  SHALL count completed output transfers.

Function
REQ-014 The block SHALL route each input item to exactly one of 8 channels through a one-entry output register, with states IDLE (empty) and HOLD (full).
REQ-015 Accept = in_valid && in_ready; on accept, in_data, target one-hot and index SHALL be registered, with state HOLD from the next cycle (latency 1 cycle).
REQ-016 Target selection SHALL start at rotation pointer ptr (3 bits); see REQ-025/026.
REQ-017 In HOLD, out_valid, out_data and out_sel SHALL stay stable until out_ready[out_sel] is high (drain).
REQ-018 On drain: xfer_cnt += 1 (wraps 0xFFFF -> 0x0000); ptr = out_sel + 1 mod 8 (7 wraps to 0).
REQ-019 in_ready SHALL be high in IDLE, and in HOLD only when out_ready[out_sel] is high (drain-and-refill in the same cycle, one item per cycle throughput).
REQ-020 Simultaneous drain and accept: the new target SHALL be selected from the updated ptr (out_sel + 1); state stays HOLD.
REQ-021 Drain without accept SHALL return to IDLE with out_valid = 0.
REQ-022 out_ready bits of non-targeted channels SHALL be ignored.
REQ-023 Changes of en_mask while in HOLD SHALL NOT retarget the held item.
REQ-024 busy SHALL equal (state == HOLD).

Configuration
REQ-025 With DEMUX_SCHED_SKIP_EN defined, the target SHALL be the first channel with en_mask bit set, searched circularly from ptr. in_ready SHALL additionally require |en_mask; with en_mask = 0, no item is accepted.
REQ-026 Without DEMUX_SCHED_SKIP_EN, en_mask SHALL be ignored (port kept), the target SHALL be ptr (strict rotation), and in_ready SHALL follow REQ-019 alone.

Reset
REQ-027 While rst_n is low: state IDLE, ptr 0, out_valid 0, out_data 0, out_sel 0, xfer_cnt 0, in_ready 0, busy 0.
REQ-028 Reset asserted during HOLD SHALL discard the held item without counting it.
REQ-029 The first accept after reset release SHALL target channel 0 (or the first enabled channel at or after 0 under SKIP).

Structure
REQ-030 Package demux_sched_pkg SHALL hold NCH = 8, SELW = 3, CNTW = 16 and the state enum {IDLE, HOLD}.
REQ-031 The circular first-set search from ptr over an 8-bit mask SHALL be a combinational sub-module rr_pick (inputs mask, ptr; outputs idx, found).

Verification
REQ-032 Reset, then 8 items 0x10..0x17 with all out_ready = 1 -> channels 0..7 in order, one per cycle, xfer_cnt = 8.
REQ-033 Item 0xA5 to channel 0, out_ready = 0 for 3 cycles -> out_valid = 0x01 and out_data = 0xA5 held stable; in_ready = 0 until out_ready[0] rises; then xfer_cnt = 1.
REQ-034 SKIP_EN, en_mask = 0x24, 4 items -> targets 2, 5, 2, 5; with en_mask = 0x00, in_ready stays 0.
REQ-035 No SKIP_EN, en_mask = 0x00, 3 items -> targets 0, 1, 2.
REQ-036 Preload xfer_cnt to 0xFFFF via 65535 transfers, then 1 more -> xfer_cnt = 0x0000; ptr wraps 7 -> 0.
REQ-037 rst_n low mid-HOLD -> out_valid = 0 immediately, xfer_cnt = 0; next item -> channel 0.
